riscv_multicycle: RTL and testbench

RISCV_MULTICYCLE -- requirements
Module: riscv_multicycle

---
 rtl/riscv_pkg.sv | 132 +++++++++++++
 rtl/riscv_alu.sv | 24 ++
 rtl/riscv_multicycle.sv | 189 ++++++++++++++++++
 tb/tb_riscv_multicycle.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings and types for the multicycle RV32I-subset core.
package riscv_pkg;

  // Major opcodes of the supported subset.
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  // funct3 values.
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3Beq    = 3'b000;

  // funct7 values.
  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  // State encoding is visible on State_out, so the values are fixed.
  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluSlt,
    AluAnd,
    AluOr
  } alu_op_e;

  typedef enum logic [2:0] {
    KindIllegal,
    KindAlu,
    KindLoad,
    KindStore,
    KindBranch,
    KindJal
  } kind_e;

  typedef struct packed {
    kind_e       kind;
    alu_op_e     alu_op;
    logic        use_imm;
    logic [31:0] imm;
  } decode_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  // Classify an instruction word; anything outside the subset is KindIllegal.
  function automatic decode_t decode_instr(input logic [31:0] ir);
    decode_t d;
    d.kind    = KindIllegal;
    d.alu_op  = AluAdd;
    d.use_imm = 1'b1;
    d.imm     = '0;
    case (ir[6:0])
      OpcOp: begin
        d.use_imm = 1'b0;
        if (ir[31:25] == F7Base) begin
          d.kind = KindAlu;
          case (ir[14:12])
            F3AddSub: d.alu_op = AluAdd;
            F3Slt:    d.alu_op = AluSlt;
            F3And:    d.alu_op = AluAnd;
            F3Or:     d.alu_op = AluOr;
            default:  d.kind   = KindIllegal;
          endcase
        end else if (ir[31:25] == F7Sub && ir[14:12] == F3AddSub) begin
          d.kind   = KindAlu;
          d.alu_op = AluSub;
        end
      end
      OpcOpImm: begin
        d.imm  = imm_i(ir);
        d.kind = KindAlu;
        case (ir[14:12])
          F3AddSub: d.alu_op = AluAdd;
          F3Slt:    d.alu_op = AluSlt;
          F3And:    d.alu_op = AluAnd;
          F3Or:     d.alu_op = AluOr;
          default:  d.kind   = KindIllegal;
        endcase
      end
      OpcLoad: begin
        d.imm = imm_i(ir);
        if (ir[14:12] == F3Word) d.kind = KindLoad;
      end
      OpcStore: begin
        d.imm = imm_s(ir);
        if (ir[14:12] == F3Word) d.kind = KindStore;
      end
      OpcBranch: begin
        d.imm     = imm_b(ir);
        d.use_imm = 1'b0;
        d.alu_op  = AluSub;
        if (ir[14:12] == F3Beq) d.kind = KindBranch;
      end
      OpcJal: begin
        d.imm  = imm_j(ir);
        d.kind = KindJal;
      end
      default: d.kind = KindIllegal;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational ALU for the multicycle core.
module riscv_alu
  import riscv_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  // Arithmetic wraps modulo 2^32; slt compares as signed.
  always_comb begin
    result_o = '0;
    case (op_i)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluSlt:  result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I-subset core with internal register file and data memory.
module riscv_multicycle
  import riscv_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction,
  input  logic        Instr_valid,
  output logic        Instr_req,
  output logic [31:0] PC_out,
  output logic [31:0] ALUResult_out,
  output logic [31:0] Mem_ReadData_out,
  output logic [2:0]  State_out,
  output logic        Trap_out
);

  localparam int unsigned AddrW = $clog2(DMEM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;

  logic [31:0] rf_q [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic             rf_we;
  logic [31:0]      rf_wdata;
  logic             dm_we;
  logic [AddrW-1:0] dm_idx;

  decode_t     dec;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] op_a, op_b, alu_res;
  logic [31:0] pc_plus4, pc_target;
  logic        addr_bad;

  assign dec = decode_instr(ir_q);
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + imm_q;
  assign dm_idx    = alu_q[AddrW+1:2];

  // Operand selection: jal reuses the ALU to form the link address.
  always_comb begin
    op_a = (dec.kind == KindJal) ? pc_q : a_q;
    if (dec.kind == KindJal) begin
      op_b = 32'd4;
    end else if (dec.use_imm) begin
      op_b = imm_q;
    end else begin
      op_b = b_q;
    end
  end

  riscv_alu u_alu (
    .op_i    (dec.alu_op),
    .a_i     (op_a),
    .b_i     (op_b),
    .result_o(alu_res)
  );

  // Misaligned or out-of-range data addresses trap before any memory access.
  assign addr_bad = (alu_res[1:0] != 2'b00) || (alu_res[31:2] >= 30'(DMEM_WORDS));

  // Next-state, datapath register and write-enable logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_wdata = alu_q;
    dm_we    = 1'b0;
    case (state_q)
      StFetch: begin
        if (Instr_valid) begin
          ir_d    = Instruction;
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d     = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
        b_d     = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
        imm_d   = dec.imm;
        state_d = (dec.kind == KindIllegal) ? StTrap : StExecute;
      end
      StExecute: begin
        alu_d = alu_res;
        case (dec.kind)
          KindAlu:              state_d = StWriteback;
          KindLoad, KindStore:  state_d = addr_bad ? StTrap : StMemory;
          KindBranch: begin
            if (a_q == b_q) begin
              if (pc_target[1:0] != 2'b00) begin
                state_d = StTrap;
              end else begin
                pc_d    = pc_target;
                state_d = StFetch;
              end
            end else begin
              pc_d    = pc_plus4;
              state_d = StFetch;
            end
          end
          KindJal: state_d = (pc_target[1:0] != 2'b00) ? StTrap : StWriteback;
          default: state_d = StTrap;
        endcase
      end
      StMemory: begin
        if (dec.kind == KindStore) begin
          dm_we   = 1'b1;
          pc_d    = pc_plus4;
          state_d = StFetch;
        end else begin
          mdr_d   = dmem[dm_idx];
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        rf_we    = (rd != 5'd0);
        rf_wdata = (dec.kind == KindLoad) ? mdr_q : alu_q;
        pc_d     = (dec.kind == KindJal) ? pc_target : pc_plus4;
        state_d  = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // Control and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
    end
  end

  // Register file; x0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  // Data memory keeps its contents across reset; a store in flight is dropped.
  always_ff @(posedge clk) begin
    if (dm_we && !rst) dmem[dm_idx] <= b_q;
  end

  assign Instr_req        = (state_q == StFetch) && !rst;
  assign PC_out           = pc_q;
  assign ALUResult_out    = alu_q;
  assign Mem_ReadData_out = mdr_q;
  assign State_out        = state_q;
  assign Trap_out         = (state_q == StTrap);

endmodule

// File: tb/tb_riscv_multicycle.sv
// Self-checking bench: random and directed programs against an ISA-level model.
module tb_riscv_multicycle;

  localparam int unsigned DMEM_WORDS = 64;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instruction = '0;
  logic        Instr_valid = 1'b0;
  logic        Instr_req;
  logic [31:0] PC_out, ALUResult_out, Mem_ReadData_out;
  logic [2:0]  State_out;
  logic        Trap_out;

  riscv_multicycle #(
    .DMEM_WORDS(DMEM_WORDS),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .Instruction     (Instruction),
    .Instr_valid     (Instr_valid),
    .Instr_req       (Instr_req),
    .PC_out          (PC_out),
    .ALUResult_out   (ALUResult_out),
    .Mem_ReadData_out(Mem_ReadData_out),
    .State_out       (State_out),
    .Trap_out        (Trap_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural model state.
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [DMEM_WORDS];
  logic [31:0] m_pc, m_mdr;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic m_write(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) m_regs[rd] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc  = RESET_PC;
    m_mdr = '0;
  endtask

  // Executes one instruction on the model; reports the cycle count the core
  // should take from acceptance to FETCH (or to TRAP) and the expected ALU output.
  task automatic model_step(input logic [31:0] ins, output int cyc, output bit trap,
                            output bit alu_chk, output logic [31:0] alu_exp);
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, ii, is, ib, ij, res, addr, tgt;
    bit          legal;
    op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12];
    rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
    a = m_regs[rs1]; b = m_regs[rs2];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    cyc = 2; trap = 1'b1; alu_chk = 1'b0; alu_exp = '0; res = '0; legal = 1'b1;
    if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h33) begin
        case ({f7, f3})
          {7'h00, 3'd0}: res = a + b;
          {7'h20, 3'd0}: res = a - b;
          {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd7}: res = a & b;
          {7'h00, 3'd6}: res = a | b;
          default:       legal = 1'b0;
        endcase
      end else begin
        case (f3)
          3'd0:    res = a + ii;
          3'd2:    res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd7:    res = a & ii;
          3'd6:    res = a | ii;
          default: legal = 1'b0;
        endcase
      end
      if (legal) begin
        m_write(rd, res);
        cyc = 4; trap = 1'b0; alu_chk = 1'b1; alu_exp = res; m_pc = m_pc + 4;
      end
    end else if ((op == 7'h03 || op == 7'h23) && f3 == 3'd2) begin
      addr = a + ((op == 7'h03) ? ii : is);
      cyc  = 3;
      if (addr[1:0] == 2'b00 && addr[31:2] < DMEM_WORDS) begin
        trap = 1'b0; alu_chk = 1'b1; alu_exp = addr; m_pc = m_pc + 4;
        if (op == 7'h03) begin
          m_mdr = m_mem[int'(addr[31:2])];
          m_write(rd, m_mdr);
          cyc = 5;
        end else begin
          m_mem[int'(addr[31:2])] = b;
          cyc = 4;
        end
      end
    end else if (op == 7'h63 && f3 == 3'd0) begin
      tgt = m_pc + ib;
      cyc = 3;
      if (a != b) begin
        trap = 1'b0; m_pc = m_pc + 4;
      end else if (tgt[1:0] == 2'b00) begin
        trap = 1'b0; m_pc = tgt;
      end
    end else if (op == 7'h6f) begin
      tgt = m_pc + ij;
      cyc = 3;
      if (tgt[1:0] == 2'b00) begin
        m_write(rd, m_pc + 4);
        trap = 1'b0; cyc = 4; m_pc = tgt;
      end
    end
  endtask

  // Offers one instruction after some idle FETCH cycles and checks the result.
  task automatic exec_one(input logic [31:0] ins, input int stalls);
    int          cyc_exp, cyc;
    bit          trap, alu_chk;
    logic [31:0] alu_exp;
    check("pc_at_fetch", PC_out, m_pc);
    for (int s = 0; s < stalls; s++) begin
      Instr_valid = 1'b0;
      Instruction = $urandom;
      @(posedge clk); @(negedge clk);
      check("stall_state", 32'(State_out), 32'd0);
      check("stall_req", 32'(Instr_req), 32'd1);
      check("stall_pc", PC_out, m_pc);
    end
    model_step(ins, cyc_exp, trap, alu_chk, alu_exp);
    Instr_valid = 1'b1;
    Instruction = ins;
    @(posedge clk); @(negedge clk);
    cyc = 1;
    while (State_out != 3'd0 && State_out != 3'd7 && cyc < 12) begin
      Instr_valid = 1'($urandom_range(0, 1));
      Instruction = $urandom;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    Instr_valid = 1'b0;
    check("latency", 32'(cyc), 32'(cyc_exp));
    check("state_end", 32'(State_out), trap ? 32'd7 : 32'd0);
    check("trap_out", 32'(Trap_out), 32'(trap));
    check("pc_after", PC_out, m_pc);
    if (alu_chk) check("alu_result", ALUResult_out, alu_exp);
    if (!trap) check("mem_rdata", Mem_ReadData_out, m_mdr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    Instr_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    model_reset();
    check("rst_state", 32'(State_out), 32'd0);
    check("rst_pc", PC_out, RESET_PC);
    check("rst_alu", ALUResult_out, 32'd0);
    check("rst_mdr", Mem_ReadData_out, 32'd0);
    check("rst_trap", 32'(Trap_out), 32'd0);
    check("rst_req_low", 32'(Instr_req), 32'd0);
    rst = 1'b0;
    #1;
    check("req_after_rst", 32'(Instr_req), 32'd1);
  endtask

  // TRAP must ignore offered instructions and hold everything still.
  task automatic trap_hold();
    for (int i = 0; i < 3; i++) begin
      Instr_valid = 1'b1;
      Instruction = 32'h00A00093;
      @(posedge clk); @(negedge clk);
      check("trap_state", 32'(State_out), 32'd7);
      check("trap_req", 32'(Instr_req), 32'd0);
      check("trap_pc", PC_out, m_pc);
      check("trap_flag", 32'(Trap_out), 32'd1);
    end
    Instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    int         k, sel;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    k   = int'($urandom_range(0, 8));
    sel = int'($urandom_range(0, 4));
    case (sel)
      0, 1:    f3 = 3'd0;
      2:       f3 = 3'd2;
      3:       f3 = 3'd7;
      default: f3 = 3'd6;
    endcase
    case (k)
      0, 1, 2: return enc_r((sel == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      3, 4:    return enc_i(int'($urandom_range(0, 4095)) - 2048, rs1, f3, rd, 7'h13);
      5:       return enc_i(4 * int'($urandom_range(0, DMEM_WORDS - 1)), 5'd0, 3'd2, rd, 7'h03);
      6:       return enc_s(4 * int'($urandom_range(0, DMEM_WORDS - 1)), rs2, 5'd0);
      7:       return enc_b(4 * (int'($urandom_range(0, 8)) - 4), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)));
      default: return enc_j(4 * (int'($urandom_range(0, 16)) - 8), rd);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] traps [7];
    logic [31:0] loop_prog [4];
    logic [31:0] pcb;
    int          taken, n, idx, cyc;

    for (int i = 0; i < int'(DMEM_WORDS); i++) m_mem[i] = 'x;
    model_reset();
    do_reset();

    // addi x1,x0,10 with no stall.
    exec_one(32'h00A00093, 0);

    // Store/load program: mem word 2 ends up holding 30.
    exec_one(enc_i(10, 5'd0, 3'd0, 5'd1, 7'h13), 0);
    exec_one(enc_i(20, 5'd0, 3'd0, 5'd2, 7'h13), 0);
    exec_one(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 0);
    exec_one(enc_s(8, 5'd3, 5'd0), 0);
    exec_one(enc_i(8, 5'd0, 3'd2, 5'd12, 7'h03), 0);
    check("lw_value_30", Mem_ReadData_out, 32'd30);

    // Three idle FETCH cycles.
    exec_one(enc_i(5, 5'd1, 3'd0, 5'd4, 7'h13), 3);

    // Reset while a store sits in MEMORY: the word must keep its old value.
    exec_one(enc_i(77, 5'd0, 3'd0, 5'd5, 7'h13), 0);
    Instr_valid = 1'b1;
    Instruction = enc_s(8, 5'd5, 5'd0);
    @(posedge clk); @(negedge clk);
    Instr_valid = 1'b0;
    cyc = 0;
    while (State_out != 3'd3 && cyc < 8) begin
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    check("reach_memory", 32'(State_out), 32'd3);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    model_reset();
    check("midsw_state", 32'(State_out), 32'd0);
    check("midsw_pc", PC_out, RESET_PC);
    rst = 1'b0;
    #1;
    exec_one(enc_i(8, 5'd0, 3'd2, 5'd12, 7'h03), 0);

    // Give every memory word a known value.
    for (int i = 0; i < int'(DMEM_WORDS); i++) begin
      exec_one(enc_i(int'($urandom_range(0, 4095)) - 2048, 5'd0, 3'd0, 5'd1, 7'h13), 0);
      exec_one(enc_s(4 * i, 5'd1, 5'd0), 0);
    end

    // Random legal traffic.
    for (int i = 0; i < 150; i++) exec_one(rand_instr(), int'($urandom_range(0, 2)));

    // Faulting instructions, each followed by reset and a memory probe.
    traps[0] = enc_i(2, 5'd0, 3'd2, 5'd12, 7'h03);
    traps[1] = enc_s(9, 5'd0, 5'd0);
    traps[2] = enc_s(4 * int'(DMEM_WORDS), 5'd1, 5'd0);
    traps[3] = enc_b(2, 5'd0, 5'd0);
    traps[4] = enc_j(6, 5'd1);
    traps[5] = 32'h0000_0000;
    traps[6] = enc_r(7'h20, 5'd2, 5'd1, 3'd2, 5'd3);
    for (int t = 0; t < 7; t++) begin
      exec_one(enc_i(int'($urandom_range(1, 2000)), 5'd0, 3'd0, 5'd1, 7'h13), 0);
      exec_one(traps[t], int'($urandom_range(0, 2)));
      trap_hold();
      do_reset();
      exec_one(enc_i(8, 5'd0, 3'd2, 5'd12, 7'h03), 0);
    end

    // Countdown loop placed at 0x44.
    do_reset();
    exec_one(enc_j(32'h44, 5'd0), 0);
    loop_prog[0] = enc_i(2, 5'd0, 3'd0, 5'd15, 7'h13);
    loop_prog[1] = enc_i(-1, 5'd15, 3'd0, 5'd15, 7'h13);
    loop_prog[2] = enc_b(8, 5'd0, 5'd15);
    loop_prog[3] = enc_j(-8, 5'd0);
    taken = 0;
    n = 0;
    while (m_pc != 32'h54 && n < 40) begin
      idx = int'((m_pc - 32'h44) >> 2);
      if (idx < 0 || idx > 3) break;
      pcb = PC_out;
      exec_one(loop_prog[idx], int'($urandom_range(0, 1)));
      if (idx == 2 && PC_out != pcb + 32'd4) taken++;
      n++;
    end
    check("loop_exit_pc", PC_out, 32'h54);
    check("beq_taken_once", 32'(taken), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
